// File: rtl/ifb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ifb_pkg                                                 |
// | Desc     : Shared types and constants for the instruction prefetch |
// |            buffer (FIFO entry, FSM states, word increment).        |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package ifb_pkg;

    localparam logic [29:0] WORD_INC = 30'd1;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ifetch_buffer_if                                        |
// | Desc     : Core-side fetch port and ROM-side request port of the   |
// |            prefetch buffer.                                        |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface ifetch_buffer_if;

    logic [31:0] core_addr;
    logic        core_ack;
    logic [31:0] core_data;
    logic        core_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    // Environment side: the core and the instruction ROM
    modport master (
        output core_addr, core_ack, mem_valid, mem_data,
        input  core_data, core_valid, mem_req, mem_addr
    );

    // Buffer side
    modport slave (
        input  core_addr, core_ack, mem_valid, mem_data,
        output core_data, core_valid, mem_req, mem_addr
    );

endinterface
`default_nettype wire

// File: rtl/ifb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ifb_fifo                                                |
// | Desc     : Power-of-two FIFO of fetch entries with synchronous     |
// |            clear and same-cycle push/pop.                          |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module ifb_fifo
    import ifb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/ifetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ifetch_buffer                                           |
// | Desc     : Sequential instruction prefetcher between a core and a  |
// |            variable-latency ROM; flushes on PC discontinuity.      |
// |            Define IFB_STATS_EN to add hit/flush counters.          |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module ifetch_buffer
    import ifb_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset_n,
    ifetch_buffer_if.slave bus
`ifdef IFB_STATS_EN
    ,
    output logic [31:0]    stat_hits,
    output logic [31:0]    stat_flushes
`endif
);

    localparam int               CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [29:0]      RESET_WORD = RESET_ADDR[31:2];

    fsm_state_t       state_q, state_d;
    logic [29:0]      fetch_addr_q, fetch_addr_d;
    logic [29:0]      pending_q, pending_d;
    logic [29:0]      mem_word_q, mem_word_d;
    logic             mem_req_q, mem_req_d;

    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             fifo_full_unused;
    logic             hit;
    logic             miss;
    logic             push;
    logic             pop;
    logic [29:0]      core_word;
    logic [29:0]      expected_addr;
    logic             unused_core_lsb;

    assign core_word       = bus.core_addr[31:2];
    assign unused_core_lsb = ^bus.core_addr[1:0];

    // While a request is in flight, the address it will deliver is the one to compare against
    always_comb begin
        hit           = !empty && (head.addr == core_word);
        expected_addr = (state_q == WAIT) ? pending_q : fetch_addr_q;
        miss          = empty ? (expected_addr != core_word) : !hit;
        pop           = hit && bus.core_ack;
    end

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pending_d    = pending_q;
        mem_word_d   = mem_word_q;
        mem_req_d    = 1'b0;
        push         = 1'b0;

        if (miss) begin
            fetch_addr_d = core_word;
        end

        case (state_q)
            IDLE: begin
                if (!miss && (count < DEPTH_CNT)) begin
                    mem_req_d  = 1'b1;
                    mem_word_d = fetch_addr_q;
                    pending_d  = fetch_addr_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_valid) begin
                    state_d = IDLE;
                    if (!miss) begin
                        push         = 1'b1;
                        fetch_addr_d = fetch_addr_q + WORD_INC;
                    end
                end else if (miss) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.mem_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= RESET_WORD;
            pending_q    <= RESET_WORD;
            mem_word_q   <= '0;
            mem_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pending_q    <= pending_d;
            mem_word_q   <= mem_word_d;
            mem_req_q    <= mem_req_d;
        end
    end

    assign push_entry = '{addr: pending_q, instr: bus.mem_data};

    ifb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (miss),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (fifo_full_unused)
    );

    assign bus.core_valid = hit;
    assign bus.core_data  = hit ? head.instr : 32'h0;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = {mem_word_q, 2'b00};

`ifdef IFB_STATS_EN
    logic [31:0] stat_hits_q;
    logic [31:0] stat_flushes_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_hits_q    <= '0;
            stat_flushes_q <= '0;
        end else begin
            if (pop && (stat_hits_q != 32'hFFFF_FFFF)) begin
                stat_hits_q <= stat_hits_q + 32'd1;
            end
            if (miss && (stat_flushes_q != 32'hFFFF_FFFF)) begin
                stat_flushes_q <= stat_flushes_q + 32'd1;
            end
        end
    end

    assign stat_hits    = stat_hits_q;
    assign stat_flushes = stat_flushes_q;
`endif

endmodule
`default_nettype wire

// File: doc/ifetch_buffer.md
IFETCH_BUFFER -- requirements
Module: ifetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter RESET_ADDR, default 32'h0000_0000, first prefetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 core_addr  input  32  PC the core is fetching (i_address); bits [1:0] ignored.
REQ-006 core_ack  input  1  core consumes the word presented this cycle.
REQ-007 core_data  output  32  instruction for core_addr (drives i_data_read).
REQ-008 core_valid  output  1  core_data is valid for core_addr (drives i_data_valid).
REQ-009 mem_req  output  1  one-cycle registered read request to instruction ROM.
REQ-010 mem_addr  output  32  registered word address of the request, bits [1:0]=0.
REQ-011 mem_valid  input  1  ROM returns data for the outstanding request, at least 1 cycle after mem_req.
REQ-012 mem_data  input  32  ROM read data, sampled when mem_valid=1.

Function
REQ-013 FIFO entry = {addr[31:2], instr[31:0]}; head is the oldest entry.
REQ-014 hit = !empty && head.addr == core_addr[31:2]; core_valid = hit and core_data = head.instr, both combinational.
REQ-015 Pop head when hit && core_ack.
REQ-016 Miss condition = (!empty && !hit) || (empty && expected_addr != core_addr[31:2]); expected_addr = pending address in WAIT, else fetch_addr.
REQ-017 On miss: FIFO cleared, fetch_addr <= core_addr[31:2]; the same cycle's core_ack is ignored.
REQ-018 FSM IDLE: if count < DEPTH and no miss, assert mem_req, mem_addr <= fetch_addr, latch pending address, go to WAIT.
REQ-019 FSM WAIT: on mem_valid without miss, push {pending, mem_data}, fetch_addr <= fetch_addr+1 (word), go to IDLE; on miss without mem_valid, go to DROP; on miss with mem_valid, discard data, go to IDLE.
REQ-020 FSM DROP: on mem_valid, discard data and go to IDLE; mem_req stays 0.
REQ-021 Exactly one request is outstanding at a time; counting the reserved slot, the FIFO never overflows, and a push when full never occurs.
REQ-022 Same-cycle push and pop are allowed; count stays unchanged.
REQ-023 fetch_addr wraps from word 0x3FFF_FFFF to 0 without error.
REQ-024 mem_valid in IDLE is ignored.

Reset
REQ-025 While reset_n=0: FIFO empty, FSM=IDLE, fetch_addr=RESET_ADDR[31:2], mem_req=0, mem_addr=0, core_valid=0, core_data=0.
REQ-026 Reset asserted mid-request abandons it; a later stale mem_valid lands in IDLE and is ignored.

Configuration
REQ-027 Macro IFB_STATS_EN defined: add outputs stat_hits[31:0] (count of hit&&core_ack) and stat_flushes[31:0] (count of misses), both saturating at 32'hFFFF_FFFF and reset to 0.
REQ-028 IFB_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-029 Package ifb_pkg holds the fetch-entry struct typedef, the FSM state enum {IDLE, WAIT, DROP}, and the word-increment constant.
REQ-030 Storage is one sub-module, ifb_fifo (DEPTH, clear, push, pop, head, count, empty, full), reset by the same async reset_n.

Verification
REQ-031 Reset release with core_addr=0 and ROM latency 1: mem_req at 0x0, 0x4, 0x8, 0xC; core_valid with word @0 within 3 cycles of reset release; FIFO fills to 4 with no 5th request until a pop.
REQ-032 Sequential run 0x0..0x3C with core_ack=1 every valid cycle: 16 instructions delivered in order, no miss; with IFB_STATS_EN, stat_hits=16 and stat_flushes=0.
REQ-033 Jump: FIFO holds 0x10..0x1C and core_addr switches to 0x100: core_valid=0 that cycle, FIFO cleared, next mem_addr=0x100.
REQ-034 Jump to 0x200 while in WAIT with ROM latency 5: FSM enters DROP, stale data is never presented, next mem_addr=0x200, stat_flushes +1.
REQ-035 Miss and mem_valid in the same cycle: data discarded, FSM goes to IDLE, next request is to the new core_addr.
REQ-036 fetch_addr at 0xFFFF_FFFC: next mem_addr=0x0000_0000; reset_n pulsed low during WAIT then late mem_valid: no push, FIFO empty.
